sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It replaces the fixed 4-entry, 16-bit register-bank-plus-read-mux arrangement with generic WIDTH/DEPTH storage. It adds wrapping read/write pointers, an occupancy count, full/empty flags, error pulses and a registered read port. It sits between a producer issuing push and a consumer issuing pop, in the same datapath as the existing FIFO logic.

---
 rtl/sync_fifo_param.sv | 97 +++++++++
 tb/tb_sync_fifo_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read port, occupancy count and error pulses.
// Latency: push data is readable on the cycle after the push; a pop returns its word 1 cycle later.
// Backpressure: rejects a push when full (unless a pop is accepted in the same cycle) and a pop when empty, with a one-cycle pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears pointers, count, dout, pulses; not storage)
//   push/din   write request and data, sampled on the same edge
//   pop        read request
//   dout       registered read data; dout_valid marks a newly popped word
//   full/empty decodes of count
//   count      occupancy 0..DEPTH
//   overflow   one-cycle pulse for a rejected push
//   underflow  one-cycle pulse for a rejected pop
//
// Optional build macro FIFO_TRISTATE_OUT_EN: dout floats to Z whenever dout_valid is low,
// for legacy shared read buses. The internal data register keeps its value either way.

module sync_fifo_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] dout_q;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign pop_ok  = pop & ~empty;
  // A full FIFO can still take a word if one leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_q     <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        // Reads the pre-edge contents, so a same-cycle write to this slot
        // (full FIFO, push+pop) never leaks the incoming word.
        dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      dout_valid <= pop_ok;
      overflow   <= push & ~push_ok;
      underflow  <= pop & ~pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; reset only forgets the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

`ifdef FIFO_TRISTATE_OUT_EN
  assign dout = dout_valid ? dout_q : {WIDTH{1'bz}};
`else
  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=16, DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// No waits on DUT events: every phase runs a fixed number of cycles.

module tb_sync_fifo_param;

  logic        clk;
  logic        rst;
  logic        push;
  logic [15:0] din;
  logic        pop;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int n_cmp;
  int n_err;

  sync_fifo_param #(.WIDTH(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .din        (din),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected dout when the output is not carrying fresh data.
  function automatic logic [15:0] dexp(input logic [15:0] held, input logic vld);
`ifdef FIFO_TRISTATE_OUT_EN
    return vld ? held : 16'hzzzz;
`else
    return held;
`endif
  endfunction

  task automatic cyc(input logic p, input logic [15:0] d, input logic q);
    push = p;
    din  = d;
    pop  = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    din  = 16'h0000;
  endtask

  logic [15:0] fill_v [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    fill_v[0] = 16'h1111;
    fill_v[1] = 16'h2222;
    fill_v[2] = 16'h3333;
    fill_v[3] = 16'h4444;
    push = 1'b0;
    pop  = 1'b0;
    din  = 16'h0000;
    rst  = 1'b1;

    // Reset then idle
    cyc(1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    chk("rst_empty", {15'd0, empty}, 16'd1);
    chk("rst_full", {15'd0, full}, 16'd0);
    chk("rst_count", {13'd0, count}, 16'd0);
    chk("rst_dout", dout, dexp(16'h0000, 1'b0));
    chk("rst_dvld", {15'd0, dout_valid}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    chk("rst_udf", {15'd0, underflow}, 16'd0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, fill_v[i], 1'b0);
      chk("fill_count", {13'd0, count}, 16'(i + 1));
    end
    chk("fill_full", {15'd0, full}, 16'd1);
    chk("fill_empty", {15'd0, empty}, 16'd0);

    // Drain
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      chk("drain_dout", dout, fill_v[i]);
      chk("drain_dvld", {15'd0, dout_valid}, 16'd1);
    end
    chk("drain_empty", {15'd0, empty}, 16'd1);
    chk("drain_count", {13'd0, count}, 16'd0);
    cyc(1'b0, 16'h0, 1'b0);
    chk("idle_dvld", {15'd0, dout_valid}, 16'd0);
    chk("idle_dout", dout, dexp(16'h4444, 1'b0));

    // Refill, then overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, fill_v[i], 1'b0);
    cyc(1'b1, 16'h5555, 1'b0);
    chk("ovf_pulse", {15'd0, overflow}, 16'd1);
    chk("ovf_count", {13'd0, count}, 16'd4);
    cyc(1'b0, 16'h0, 1'b0);
    chk("ovf_clear", {15'd0, overflow}, 16'd0);

    // Push+pop when full: oldest word out, count stays 4
    cyc(1'b1, 16'hAAAA, 1'b1);
    chk("fpp_dout", dout, 16'h1111);
    chk("fpp_dvld", {15'd0, dout_valid}, 16'd1);
    chk("fpp_count", {13'd0, count}, 16'd4);
    chk("fpp_ovf", {15'd0, overflow}, 16'd0);
    cyc(1'b0, 16'h0, 1'b1);
    chk("fpp_pop1", dout, 16'h2222);
    cyc(1'b0, 16'h0, 1'b1);
    chk("fpp_pop2", dout, 16'h3333);
    cyc(1'b0, 16'h0, 1'b1);
    chk("fpp_pop3", dout, 16'h4444);
    cyc(1'b0, 16'h0, 1'b1);
    chk("fpp_pop4", dout, 16'hAAAA);
    chk("fpp_empty", {15'd0, empty}, 16'd1);

    // Underflow on empty
    cyc(1'b0, 16'h0, 1'b1);
    chk("udf_pulse", {15'd0, underflow}, 16'd1);
    chk("udf_dvld", {15'd0, dout_valid}, 16'd0);
    chk("udf_dout", dout, dexp(16'hAAAA, 1'b0));
    chk("udf_count", {13'd0, count}, 16'd0);
    cyc(1'b0, 16'h0, 1'b0);
    chk("udf_clear", {15'd0, underflow}, 16'd0);

    // Push+pop when empty: no fall-through
    cyc(1'b1, 16'hBBBB, 1'b1);
    chk("epp_udf", {15'd0, underflow}, 16'd1);
    chk("epp_count", {13'd0, count}, 16'd1);
    chk("epp_dvld", {15'd0, dout_valid}, 16'd0);
    cyc(1'b0, 16'h0, 1'b1);
    chk("epp_dout", dout, 16'hBBBB);
    chk("epp_dvld2", {15'd0, dout_valid}, 16'd1);
    chk("epp_count2", {13'd0, count}, 16'd0);

    // Wrap-around at occupancy 2
    cyc(1'b1, 16'h1000, 1'b0);
    cyc(1'b1, 16'h1001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'h1002 + 16'(i), 1'b1);
      chk("wrap_dout", dout, 16'h1000 + 16'(i));
      chk("wrap_count", {13'd0, count}, 16'd2);
    end
    cyc(1'b0, 16'h0, 1'b1);
    chk("wrap_tail0", dout, 16'h100A);
    cyc(1'b0, 16'h0, 1'b1);
    chk("wrap_tail1", dout, 16'h100B);
    chk("wrap_empty", {15'd0, empty}, 16'd1);

    // Reset mid-operation with push+pop
    cyc(1'b1, 16'hC000, 1'b0);
    cyc(1'b1, 16'hC001, 1'b0);
    cyc(1'b1, 16'hC002, 1'b0);
    chk("mid_count3", {13'd0, count}, 16'd3);
    rst = 1'b1;
    cyc(1'b1, 16'hDDDD, 1'b1);
    rst = 1'b0;
    chk("mid_count", {13'd0, count}, 16'd0);
    chk("mid_empty", {15'd0, empty}, 16'd1);
    chk("mid_dvld", {15'd0, dout_valid}, 16'd0);
    chk("mid_ovf", {15'd0, overflow}, 16'd0);
    chk("mid_udf", {15'd0, underflow}, 16'd0);
    chk("mid_dout", dout, dexp(16'h0000, 1'b0));
    cyc(1'b1, 16'h0F0F, 1'b0);
    chk("post_count", {13'd0, count}, 16'd1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("post_dout", dout, 16'h0F0F);
    chk("post_dvld", {15'd0, dout_valid}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
